// File: rtl/fifo_pkg.sv
// Shared helpers for the peek FIFO family: pointer/level widths
// and the parameter legality check used at elaboration.
package fifo_pkg;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_ok(
        input int depth,
        input int peek_bits,
        input int af_level
    );
        return (depth >= 2) && (depth <= 256)
            && ((depth & (depth - 1)) == 0)
            && ((1 << peek_bits) <= depth)
            && (af_level >= 1) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/peek_fifo_core_if.sv
// Data/control bundle between the tile wrapper and the peek FIFO.
// master drives writes/pops/peeks, slave returns data and status.
interface peek_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int DEPTH     = 16,
    parameter int PEEK_BITS = 2
);
    localparam int LW = lvl_bits(DEPTH);

    logic                 write_en;
    logic [WIDTH-1:0]     data_in;
    logic                 pop;
    logic [PEEK_BITS-1:0] peek;
    logic                 clear_flags;
    logic [WIDTH-1:0]     data_out;
    logic                 empty_n;
    logic                 full_n;
    logic [LW-1:0]        level;
    logic                 almost_full;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output write_en, data_in, pop, peek, clear_flags,
        input  data_out, empty_n, full_n, level,
        input  almost_full, overflow, underflow
    );

    modport slave (
        input  write_en, data_in, pop, peek, clear_flags,
        output data_out, empty_n, full_n, level,
        output almost_full, overflow, underflow
    );

endinterface

// File: rtl/fifo_regfile.sv
// FIFO storage: one write port, one combinational read port.
// Kept separate so the flop array can become a latch array.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16,
    localparam int PW   = ptr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/peek_fifo_core.sv
// Circular register FIFO with indexed peek, level, almost-full
// threshold and sticky overflow/underflow flags.
module peek_fifo_core
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int DEPTH     = 16,
    parameter int PEEK_BITS = 2,
    parameter int AF_LEVEL  = DEPTH - 2
) (
    input logic        clk,
    input logic        reset_n,
    peek_fifo_if.slave bus
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int LW = lvl_bits(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);

    if (!params_ok(DEPTH, PEEK_BITS, AF_LEVEL)) begin : g_bad_params
        $error("peek_fifo_core: illegal DEPTH/PEEK_BITS/AF_LEVEL");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_addr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] data_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             is_full;
    logic             is_empty;
    logic             pop_ok;
    logic             wr_ok;
    logic             wr_drop;
    logic             pop_bad;
    logic             peek_hit;

    always_comb begin
        is_full  = (level == FULL_LVL);
        is_empty = (level == '0);
        pop_ok   = bus.pop && !is_empty;
        // A pop in the same cycle frees the slot a full write needs.
        wr_ok    = bus.write_en && (!is_full || pop_ok);
        wr_drop  = bus.write_en && is_full && !pop_ok;
        pop_bad  = bus.pop && is_empty;
        rd_addr  = rd_ptr + PW'(bus.peek);
        peek_hit = (LW'(bus.peek) < level);
    end

    fifo_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({wr_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            data_q <= peek_hit ? rd_data : '0;
            // A fresh error outranks a clear in the same cycle.
            overflow_q  <= (overflow_q && !bus.clear_flags) || wr_drop;
            underflow_q <= (underflow_q && !bus.clear_flags) || pop_bad;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.level       = level;
    assign bus.empty_n     = !is_empty;
    assign bus.full_n      = !is_full;
    assign bus.almost_full = (level >= AF_LVL);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_peek_fifo_core.sv
// Directed bench for peek_fifo_core: vector table plus
// hand-written fill/drain, overflow, wrap and async reset runs.
module tb_peek_fifo_core;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    peek_fifo_if #(.WIDTH(6), .DEPTH(16), .PEEK_BITS(2)) bus ();

    peek_fifo_core #(
        .WIDTH     (6),
        .DEPTH     (16),
        .PEEK_BITS (2),
        .AF_LEVEL  (14)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [5:0] din;
        logic       pop;
        logic [1:0] peek;
        logic       clr;
        logic [5:0] exp_dout;
        logic [4:0] exp_level;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [5:0] din,
                         input logic pop, input logic [1:0] pk,
                         input logic clr);
        bus.write_en    = we;
        bus.data_in     = din;
        bus.pop         = pop;
        bus.peek        = pk;
        bus.clear_flags = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dout"}, int'(bus.data_out), 0);
        check({tag, "_level"}, int'(bus.level), 0);
        check({tag, "_empty_n"}, int'(bus.empty_n), 0);
        check({tag, "_full_n"}, int'(bus.full_n), 1);
        check({tag, "_af"}, int'(bus.almost_full), 0);
        check({tag, "_ovf"}, int'(bus.overflow), 0);
        check({tag, "_unf"}, int'(bus.underflow), 0);
    endtask

    task automatic fill_1_to_16();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 6'(i), 1'b0, 2'd0, 1'b0);
            step();
        end
        drive(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        drive(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);

        //              we din   pop pk clr  dout  lvl ovf unf
        vecs[0]  = '{1, 6'h07, 0, 0, 0, 6'h00, 1, 0, 0};
        vecs[1]  = '{1, 6'h08, 0, 0, 0, 6'h07, 2, 0, 0};
        vecs[2]  = '{0, 6'h00, 0, 1, 0, 6'h08, 2, 0, 0};
        vecs[3]  = '{0, 6'h00, 0, 2, 0, 6'h00, 2, 0, 0};
        vecs[4]  = '{0, 6'h00, 0, 3, 0, 6'h00, 2, 0, 0};
        vecs[5]  = '{0, 6'h00, 0, 0, 0, 6'h07, 2, 0, 0};
        vecs[6]  = '{0, 6'h00, 1, 1, 0, 6'h08, 1, 0, 0};
        vecs[7]  = '{0, 6'h00, 1, 0, 0, 6'h08, 0, 0, 0};
        vecs[8]  = '{1, 6'h15, 1, 0, 0, 6'h00, 1, 0, 1};
        vecs[9]  = '{0, 6'h00, 0, 0, 0, 6'h15, 1, 0, 1};
        vecs[10] = '{0, 6'h00, 0, 0, 1, 6'h15, 1, 0, 0};
        vecs[11] = '{0, 6'h00, 1, 0, 1, 6'h15, 0, 0, 0};
        vecs[12] = '{0, 6'h00, 1, 0, 1, 6'h00, 0, 0, 1};
        vecs[13] = '{0, 6'h00, 0, 0, 1, 6'h00, 0, 0, 0};

        #12;
        check_reset_vals("reset");
        #2 reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].din, vecs[i].pop,
                  vecs[i].peek, vecs[i].clr);
            step();
            check($sformatf("vec%0d_dout", i), int'(bus.data_out),
                  int'(vecs[i].exp_dout));
            check($sformatf("vec%0d_level", i), int'(bus.level),
                  int'(vecs[i].exp_level));
            check($sformatf("vec%0d_ovf", i), int'(bus.overflow),
                  int'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_unf", i), int'(bus.underflow),
                  int'(vecs[i].exp_unf));
        end

        // Fill 1..16 with status checks at every level.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 6'(i), 1'b0, 2'd0, 1'b0);
            step();
            check($sformatf("fill%0d_level", i), int'(bus.level), i);
            check($sformatf("fill%0d_af", i), int'(bus.almost_full),
                  (i >= 14) ? 1 : 0);
            check($sformatf("fill%0d_full_n", i), int'(bus.full_n),
                  (i == 16) ? 0 : 1);
        end

        drive(1'b1, 6'h2A, 1'b0, 2'd0, 1'b0);
        step();
        check("ovf_set", int'(bus.overflow), 1);
        check("ovf_level", int'(bus.level), 16);
        drive(1'b0, 6'd0, 1'b0, 2'd0, 1'b1);
        step();
        check("ovf_clear", int'(bus.overflow), 0);

        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 6'd0, 1'b1, 2'd0, 1'b0);
            step();
            check($sformatf("drain%0d_dout", i), int'(bus.data_out), i);
        end
        drive(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        step();
        check("drain_empty_n", int'(bus.empty_n), 0);
        check("drain_level", int'(bus.level), 0);
        check("drain_tail_dout", int'(bus.data_out), 0);

        // Write and pop together on a full FIFO.
        fill_1_to_16();
        drive(1'b1, 6'h3F, 1'b1, 2'd0, 1'b0);
        step();
        check("fwp_dout", int'(bus.data_out), 1);
        check("fwp_level", int'(bus.level), 16);
        check("fwp_ovf", int'(bus.overflow), 0);
        for (int i = 2; i <= 17; i++) begin
            drive(1'b0, 6'd0, 1'b1, 2'd0, 1'b0);
            step();
            check($sformatf("fwp_pop%0d", i), int'(bus.data_out),
                  (i == 17) ? 32'h3F : i);
        end
        drive(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        check("fwp_end_level", int'(bus.level), 0);

        // Level 9 with overflow set, then async reset between edges.
        fill_1_to_16();
        drive(1'b1, 6'h2A, 1'b0, 2'd0, 1'b0);
        step();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 6'd0, 1'b1, 2'd0, 1'b0);
            step();
        end
        drive(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        check("pre_rst_level", int'(bus.level), 9);
        check("pre_rst_ovf", int'(bus.overflow), 1);
        check("pre_rst_dout", int'(bus.data_out), 7);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        reset_n = 1'b1;

        drive(1'b1, 6'h2B, 1'b0, 2'd0, 1'b0);
        step();
        check("post_rst_level", int'(bus.level), 1);
        drive(1'b0, 6'd0, 1'b0, 2'd0, 1'b0);
        step();
        check("post_rst_dout", int'(bus.data_out), 32'h2B);
        check("post_rst_empty_n", int'(bus.empty_n), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
